// File: rtl/rv_pkg.sv
// Shared types and encodings for the RV32I decode stage: ALU ops, operand
// selects, immediate formats, opcodes and the registered decode bundle.
package rv_pkg;

  localparam int RV_XLEN     = 32;
  localparam int RV_ALU_OP_W = 4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [RV_ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    alu_op_e            alu_op;
    op1_sel_e           op1_sel;
    logic               op2_sel;
    logic [RV_XLEN-1:0] imm;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [4:0]         rd_addr;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic [2:0]         funct3;
    logic               illegal;
  } decode_bundle_t;

  // alt selects SUB on 000 (R-type only) and SRA on 101
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate extraction for the I/S/B/U/J formats; every format
// is sign-extended from instr[31].
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:0]        instr,
  input  imm_type_e          imm_type,
  output logic [RV_XLEN-1:0] imm
);

  always_comb begin
    case (imm_type)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes the fetched instruction and registers the bundle
// behind a valid/ready handshake. Define DECODE_SKID_BUFFER_EN for a registered if_ready.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int ALU_OP_W = RV_ALU_OP_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         if_instr,
  input  logic [XLEN-1:0]     if_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [XLEN-1:0]     id_pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          op1_sel,
  output logic                op2_sel,
  output logic [XLEN-1:0]     imm,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic [2:0]          funct3,
  output logic                illegal
);

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  imm_type_e          imm_type;
  logic [RV_XLEN-1:0] imm_val;
  decode_bundle_t     dec;
  logic               bad;
  logic               accept;

  assign opcode = if_instr[6:0];
  assign f3     = if_instr[14:12];
  assign f7     = if_instr[31:25];

  always_comb begin
    case (opcode)
      OPC_STORE:          imm_type = IMM_S;
      OPC_BRANCH:         imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
      OPC_JAL:            imm_type = IMM_J;
      default:            imm_type = IMM_I;
    endcase
  end

  rv_imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm_val)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = if_pc;
    dec.imm      = imm_val;
    dec.rs1_addr = if_instr[19:15];
    dec.rs2_addr = if_instr[24:20];
    dec.rd_addr  = if_instr[11:7];
    dec.funct3   = f3;
    dec.alu_op   = ALU_ADD;
    dec.op1_sel  = OP1_RS1;
    bad          = 1'b0;
    case (opcode)
      OPC_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_f3(f3, f7[5]);
        bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.op2_sel   = 1'b1;
        // funct7 only matters for shifts, where the upper imm bits select SRA
        dec.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001) bad = (f7 != 7'h00);
        if (f3 == 3'b101) bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_LOAD: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.op2_sel   = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.op2_sel   = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        case (f3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_PC;
        dec.op2_sel   = 1'b1;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.op2_sel   = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_ZERO;
        dec.op2_sel   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_PC;
        dec.op2_sel   = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (if_instr[1:0] != 2'b11) bad = 1'b1;
    // illegal instructions still flow down the pipe, but as a side-effect-free NOP
    if (bad) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.alu_op    = ALU_ADD;
    end
    dec.illegal = bad;
  end

  logic           valid_q, valid_d;
  decode_bundle_t bundle_q, bundle_d;

  assign accept = if_valid && if_ready;

`ifdef DECODE_SKID_BUFFER_EN
  logic           skid_valid_q, skid_valid_d;
  decode_bundle_t skid_q, skid_d;
  logic           ready_q, ready_d;

  assign if_ready = ready_q;

  // ready is low only while the skid entry is occupied, so a refill from skid never races an accept
  always_comb begin
    valid_d      = valid_q;
    bundle_d     = bundle_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!valid_q || id_ready) begin
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        bundle_d     = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        valid_d  = 1'b1;
        bundle_d = dec;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ready_q      <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      ready_q      <= ready_d;
    end
  end
`else
  assign if_ready = !valid_q || id_ready;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (id_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign id_valid  = valid_q;
  assign id_pc     = bundle_q.pc;
  assign alu_op    = bundle_q.alu_op;
  assign op1_sel   = bundle_q.op1_sel;
  assign op2_sel   = bundle_q.op2_sel;
  assign imm       = bundle_q.imm;
  assign rs1_addr  = bundle_q.rs1_addr;
  assign rs2_addr  = bundle_q.rs2_addr;
  assign rd_addr   = bundle_q.rd_addr;
  assign reg_write = bundle_q.reg_write;
  assign mem_read  = bundle_q.mem_read;
  assign mem_write = bundle_q.mem_write;
  assign branch    = bundle_q.branch;
  assign jump      = bundle_q.jump;
  assign funct3    = bundle_q.funct3;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage (default single-entry build): handshake,
// stall, flush, async reset and per-format decode with hand-computed expectations.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, if_valid, if_ready, id_valid, id_ready;
  logic [31:0] if_instr, if_pc, id_pc, imm;
  logic [3:0]  alu_op;
  logic [1:0]  op1_sel;
  logic        op2_sel, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .alu_op(alu_op), .op1_sel(op1_sel), .op2_sel(op2_sel), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .funct3(funct3), .illegal(illegal)
  );

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset id_valid got=%b exp=0", id_valid); end
    vectors++; if (alu_op !== 4'd0) begin miscompares++; $display("FAIL reset alu_op got=%0d exp=0", alu_op); end
    vectors++; if (imm !== 32'h0) begin miscompares++; $display("FAIL reset imm got=%h exp=0", imm); end
    vectors++; if ({reg_write, mem_read, mem_write, branch, jump, illegal} !== 6'b0) begin miscompares++; $display("FAIL reset ctrl got=%b exp=000000", {reg_write, mem_read, mem_write, branch, jump, illegal}); end
  endtask

  task automatic test_add();
    id_ready = 1'b1;
    offer(32'h002081B3, 32'h100);
    #1;
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL add if_ready got=%b exp=1", if_ready); end
    tick();
    if_valid = 1'b0;
    vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL add id_valid got=%b exp=1", id_valid); end
    vectors++; if (alu_op !== 4'd0) begin miscompares++; $display("FAIL add alu_op got=%0d exp=0", alu_op); end
    vectors++; if ({rs1_addr, rs2_addr, rd_addr} !== {5'd1, 5'd2, 5'd3}) begin miscompares++; $display("FAIL add regs got=%0d/%0d/%0d exp=1/2/3", rs1_addr, rs2_addr, rd_addr); end
    vectors++; if ({op2_sel, reg_write, illegal} !== 3'b010) begin miscompares++; $display("FAIL add op2/we/ill got=%b exp=010", {op2_sel, reg_write, illegal}); end
    vectors++; if (id_pc !== 32'h100) begin miscompares++; $display("FAIL add id_pc got=%h exp=100", id_pc); end
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL add release id_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_back_to_back();
    id_ready = 1'b1;
    offer(32'h402081B3, 32'h200);
    tick();
    offer(32'h40435293, 32'h204);
    vectors++; if ({id_valid, alu_op} !== {1'b1, 4'd1}) begin miscompares++; $display("FAIL b2b sub got valid=%b op=%0d exp valid=1 op=1", id_valid, alu_op); end
    tick();
    if_valid = 1'b0;
    vectors++; if ({id_valid, alu_op} !== {1'b1, 4'd7}) begin miscompares++; $display("FAIL b2b srai got valid=%b op=%0d exp valid=1 op=7", id_valid, alu_op); end
    vectors++; if ({imm[4:0], op2_sel} !== {5'd4, 1'b1}) begin miscompares++; $display("FAIL b2b srai imm4=%0d op2=%b exp 4/1", imm[4:0], op2_sel); end
    vectors++; if ({rd_addr, rs1_addr, id_pc} !== {5'd5, 5'd6, 32'h204}) begin miscompares++; $display("FAIL b2b srai rd=%0d rs1=%0d pc=%h exp 5/6/204", rd_addr, rs1_addr, id_pc); end
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b drain id_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_imm_formats();
    id_ready = 1'b1;
    offer(32'hFFF00093, 32'h300);
    tick();
    offer(32'h123450B7, 32'h304);
    vectors++; if ({imm, alu_op, op2_sel} !== {32'hFFFFFFFF, 4'd0, 1'b1}) begin miscompares++; $display("FAIL addi imm=%h op=%0d op2=%b exp ffffffff/0/1", imm, alu_op, op2_sel); end
    tick();
    offer(32'hFE20AE23, 32'h308);
    vectors++; if ({imm, op1_sel, alu_op, reg_write} !== {32'h12345000, 2'd2, 4'd0, 1'b1}) begin miscompares++; $display("FAIL lui imm=%h op1=%0d op=%0d we=%b exp 12345000/2/0/1", imm, op1_sel, alu_op, reg_write); end
    tick();
    offer(32'h0020E463, 32'h30C);
    vectors++; if ({imm, mem_write, reg_write, funct3} !== {32'hFFFFFFFC, 1'b1, 1'b0, 3'd2}) begin miscompares++; $display("FAIL sw imm=%h mw=%b we=%b f3=%0d exp fffffffc/1/0/2", imm, mem_write, reg_write, funct3); end
    tick();
    offer(32'hFFDFF06F, 32'h310);
    vectors++; if ({imm, alu_op, branch, op2_sel} !== {32'h8, 4'd9, 1'b1, 1'b0}) begin miscompares++; $display("FAIL bltu imm=%h op=%0d br=%b op2=%b exp 8/9/1/0", imm, alu_op, branch, op2_sel); end
    tick();
    if_valid = 1'b0;
    vectors++; if ({imm, jump, op1_sel, reg_write} !== {32'hFFFFFFFC, 1'b1, 2'd1, 1'b1}) begin miscompares++; $display("FAIL jal imm=%h j=%b op1=%0d we=%b exp fffffffc/1/1/1", imm, jump, op1_sel, reg_write); end
    tick();
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    offer(32'h00100093, 32'h400);
    tick();
    offer(32'h00200113, 32'h404);
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({id_valid, rd_addr, imm, id_pc} !== {1'b1, 5'd1, 32'd1, 32'h400}) begin miscompares++; $display("FAIL stall hold%0d valid=%b rd=%0d imm=%h pc=%h exp 1/1/1/400", i, id_valid, rd_addr, imm, id_pc); end
`ifndef DECODE_SKID_BUFFER_EN
      vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL stall if_ready%0d got=%b exp=0", i, if_ready); end
`endif
      tick();
    end
    id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    vectors++; if ({id_valid, rd_addr, imm, id_pc} !== {1'b1, 5'd2, 32'd2, 32'h404}) begin miscompares++; $display("FAIL stall next valid=%b rd=%0d imm=%h pc=%h exp 1/2/2/404", id_valid, rd_addr, imm, id_pc); end
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL stall dup id_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_illegal();
    id_ready = 1'b1;
    offer(32'h00000000, 32'h500);
    tick();
    offer(32'h00002063, 32'h504);
    vectors++; if ({id_valid, illegal, reg_write, mem_write, alu_op} !== {3'b110, 1'b0, 4'd0}) begin miscompares++; $display("FAIL zero v=%b ill=%b we=%b mw=%b op=%0d exp 1/1/0/0/0", id_valid, illegal, reg_write, mem_write, alu_op); end
    tick();
    offer(32'h402091B3, 32'h508);
    vectors++; if ({illegal, branch, alu_op} !== {1'b1, 1'b0, 4'd0}) begin miscompares++; $display("FAIL br010 ill=%b br=%b op=%0d exp 1/0/0", illegal, branch, alu_op); end
    tick();
    if_valid = 1'b0;
    vectors++; if ({illegal, reg_write} !== 2'b10) begin miscompares++; $display("FAIL r_f7 ill=%b we=%b exp 1/0", illegal, reg_write); end
    tick();
  endtask

  task automatic test_flush();
    id_ready = 1'b1;
    offer(32'h002081B3, 32'h600);
    tick();
    offer(32'h402081B3, 32'h604);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush accept id_valid got=%b exp=0", id_valid); end
    id_ready = 1'b0;
    offer(32'h002081B3, 32'h608);
    tick();
    if_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL flush held id_valid got=%b exp=0", id_valid); end
    id_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstall();
    id_ready = 1'b0;
    offer(32'h402081B3, 32'h700);
    tick();
    if_valid = 1'b0;
    vectors++; if ({id_valid, alu_op} !== {1'b1, 4'd1}) begin miscompares++; $display("FAIL pre-reset valid=%b op=%0d exp 1/1", id_valid, alu_op); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({id_valid, alu_op, reg_write, rd_addr, imm, id_pc} !== '0) begin miscompares++; $display("FAIL async reset valid=%b op=%0d we=%b rd=%0d imm=%h pc=%h exp all 0", id_valid, alu_op, reg_write, rd_addr, imm, id_pc); end
    @(negedge clk);
    reset_n = 1'b1;
    id_ready = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    id_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_add();
    test_back_to_back();
    test_imm_formats();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Instruction decode stage of the RV32I core. It sits between fetch and execute and produces the ALU's control inputs (alu_op, operand selects, immediate) plus register and memory controls.
- It registers the decoded bundle, so decode-to-execute latency is 1 cycle.
- Both sides use a valid/ready handshake, and the stage supports a pipeline flush.

Parameters:
- XLEN, 32, datapath/immediate/PC width
- ALU_OP_W, 4, width of alu_op (matches ALU encoding)

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all held/incoming instructions
- if_valid  in  1  fetch offers instruction
- if_ready  out  1  stage accepts this cycle
- if_instr  in  32  raw instruction
- if_pc  in  XLEN  instruction PC
- id_valid  out  1  decoded bundle valid
- id_ready  in  1  execute accepts bundle
- id_pc  out  XLEN  PC of bundle
- alu_op  out  ALU_OP_W  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
- op1_sel  out  2  0 rs1, 1 pc, 2 zero
- op2_sel  out  1  0 rs2, 1 imm
- imm  out  XLEN  sign-extended immediate
- rs1_addr, rs2_addr, rd_addr  out  5 each
- reg_write, mem_read, mem_write, branch, jump  out  1 each
- funct3  out  3  passthrough (branch/load/store width)
- illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, reset_n=0): id_valid=0; every bundle output is 0, including alu_op=ADD(0) and imm=0.
- Accept: a transfer occurs on a clk edge when if_valid && if_ready.
  - Without the skid buffer, if_ready = !id_valid || id_ready (combinational).
  - The bundle appears on the next edge with id_valid=1.
- Stall: while id_valid && !id_ready, all id_* and bundle outputs hold stable.
- Release: id_valid drops after a handshake if no new accept occurs in the same cycle.
- Back-to-back: an accept and a release in the same cycle give a seamless 1-per-cycle throughput.
- Flush:
  - On the next edge, id_valid=0 and any held entry is discarded.
  - Flush wins over a simultaneous accept; that instruction is dropped.
  - Bundle fields may retain stale values but are don't-care while id_valid=0.
- Opcode decode:
  - R 0110011: reg_write, op2=rs2.
  - I-ALU 0010011: reg_write, op2=imm.
  - LOAD 0000011: mem_read, reg_write, ADD, imm I-type.
  - STORE 0100011: mem_write, ADD, imm S-type.
  - BRANCH 1100011: branch, imm B-type; alu_op is SUB for funct3 00x, SLT for 10x, SLTU for 11x; 010/011 are illegal.
  - JAL 1101111: jump, reg_write, op1=pc, ADD, imm J-type.
  - JALR 1100111: jump, reg_write, op1=rs1, ADD, imm I-type; funct3≠000 is illegal.
  - LUI 0110111: op1=zero, op2=imm U-type, ADD, reg_write.
  - AUIPC 0010111: op1=pc, op2=imm U-type, ADD, reg_write.
- funct3 to alu_op (R/I-ALU): 000 ADD (SUB if R and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND.
- Illegal conditions:
  - R-type with funct7 other than 0000000, or 0100000 on funct3 000/101.
  - I-shift with funct7 other than 0000000, or 0100000 on 101.
  - Unknown opcode.
  - instr[1:0]≠11.
- Illegal response: illegal=1 and the bundle is forced to a NOP (reg_write, mem_read, mem_write, branch, jump all 0; alu_op ADD). It still passes through the handshake.
- Immediate: always sign-extended from instr[31]. Shift immediates carry shamt in imm[4:0].

Optional Feature:
- Macro: DECODE_SKID_BUFFER_EN.
- Defined:
  - Adds a second entry so that if_ready is a registered signal with no combinational path from id_ready.
  - if_ready=0 only when both entries are full.
  - Order is preserved.
  - Flush clears both entries.
- Undefined: single entry with the combinational if_ready described above.

Decomposition:
- Package rv_pkg holds:
  - alu_op_e enum (values 0–9 above).
  - Opcode localparams.
  - op1_sel_e.
  - decode_bundle_t struct.
- Sub-module rv_imm_gen: combinational I/S/B/U/J immediate extraction.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) → next cycle: id_valid=1, alu_op=0, rs1=1, rs2=2, rd=3, op2_sel=0, reg_write=1, illegal=0.
- 0x402081B3 then 0x40435293 back-to-back (SUB, SRAI x5,x6,4) → alu_op=1, then 7 with imm[4:0]=4 and op2_sel=1; one output per cycle.
- 0xFFF00093 (ADDI x1,x0,-1) → imm=0xFFFFFFFF, alu_op=0. 0x123450B7 (LUI) → imm=0x12345000, op1_sel=2.
- Hold id_ready=0 for 3 cycles with if_valid=1 → outputs stable; if_ready=0 (unskid); no instruction is lost or duplicated after release.
- 0x00000000 → illegal=1, reg_write=mem_write=0. Flush asserted together with an accept → id_valid=0 next cycle.
- Assert reset_n low mid-stall → id_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
